// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: BCD real-time clock/calendar with 1 Hz prescaler,
// sec..year counting chain (Gregorian months, leap years) and a
// push-button edit state machine.
// Optional feature macro: RTC_DEBOUNCE_EN (counter debouncer per button).
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   butt_increase      raw button, increments the selected field
//   butt_decrease      raw button, decrements the selected field
//   butt_change        raw button, steps RUN->HOUR->MIN->SEC->DAY->MONTH->YEAR
//   time_bcd[23:0]     {hour, min, sec} packed BCD
//   date_bcd[31:0]     {day, month, year} packed BCD
//   edit_field[2:0]    0=RUN 1=HOUR 2=MIN 3=SEC 4=DAY 5=MONTH 6=YEAR
//   tick_1s            one-cycle pulse per second while in RUN
`timescale 1ns/1ps
module rtc_calendar_core #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [15:0] RESET_YEAR      = 16'h2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        butt_increase,
  input  logic        butt_decrease,
  input  logic        butt_change,
  output logic [23:0] time_bcd,
  output logic [31:0] date_bcd,
  output logic [2:0]  edit_field,
  output logic        tick_1s
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_HOUR  = 3'd1;
  localparam logic [2:0] S_MIN   = 3'd2;
  localparam logic [2:0] S_SEC   = 3'd3;
  localparam logic [2:0] S_DAY   = 3'd4;
  localparam logic [2:0] S_MONTH = 3'd5;
  localparam logic [2:0] S_YEAR  = 3'd6;

  // BCD two-digit increment, wrapping hi -> lo
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v >= hi)             return lo;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD two-digit decrement, wrapping lo -> hi
  function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v <= lo)             return hi;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Four-digit BCD increment; 9999 rolls naturally to 0000
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Four-digit BCD decrement; 0000 rolls naturally to 9999
  function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // 10t+u is divisible by 4 iff 2t+u is: even tens need u in {0,4,8}, odd tens u in {2,6}
  function automatic logic bcd_div4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    if (y[7:0] != 8'h00) return bcd_div4(y[7:0]);
    else                 return bcd_div4(y[15:8]);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [2:0]    r_sync1, r_sync2, r_prev;
  logic [2:0]    w_lvl, w_pulse;
  logic          w_chg, w_inc, w_dec;
  logic [2:0]    r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_tick;
  logic [7:0]    r_hour, r_min, r_sec, r_day, r_mon;
  logic [15:0]   r_year;
  logic [7:0]    w_hour_nxt, w_min_nxt, w_sec_nxt, w_day_nxt, w_mon_nxt;
  logic [15:0]   w_year_nxt;
  logic [7:0]    w_mlen, w_mlen_nxt;

  // Button synchroniser and rising-edge detector; bit order {change, decrease, increase}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {butt_change, butt_decrease, butt_increase};
      r_sync2 <= r_sync1;
      r_prev  <= w_lvl;
    end
  end

`ifdef RTC_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DBW-1:0] r_db_cnt [3];
  logic [2:0]     r_db_lvl;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_lvl <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_lvl = r_db_lvl;
`else
  assign w_lvl = r_sync2;
  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
  end
`endif

  assign w_pulse = w_lvl & ~r_prev;
  // change wins; increase and decrease together cancel
  assign w_chg   = w_pulse[2];
  assign w_inc   = w_pulse[0] & ~w_pulse[1] & ~w_chg;
  assign w_dec   = w_pulse[1] & ~w_pulse[0] & ~w_chg;
  assign w_mlen  = month_len(r_mon, is_leap(r_year));

  // Next-state: edit FSM, prescaler, counting chain and field edits
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = '0;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_day_nxt   = r_day;
    w_mon_nxt   = r_mon;
    w_year_nxt  = r_year;
    w_mlen_nxt  = 8'h31;

    if (w_chg) w_state_nxt = (r_state == S_YEAR) ? S_RUN : r_state + 3'd1;

    // Prescaler runs only while staying in RUN, so re-entry restarts it at 0
    if (r_state == S_RUN && w_state_nxt == S_RUN)
      w_presc_nxt = (r_presc == PMAX) ? '0 : r_presc + PW'(1);

    if (r_tick) begin
      w_sec_nxt = bcd2_inc(r_sec, 8'h00, 8'h59);
      if (r_sec == 8'h59) begin
        w_min_nxt = bcd2_inc(r_min, 8'h00, 8'h59);
        if (r_min == 8'h59) begin
          w_hour_nxt = bcd2_inc(r_hour, 8'h00, 8'h23);
          if (r_hour == 8'h23) begin
            w_day_nxt = bcd2_inc(r_day, 8'h01, w_mlen);
            if (r_day >= w_mlen) begin
              w_mon_nxt = bcd2_inc(r_mon, 8'h01, 8'h12);
              if (r_mon == 8'h12) w_year_nxt = bcd4_inc(r_year);
            end
          end
        end
      end
    end else if (w_inc || w_dec) begin
      case (r_state)
        S_HOUR:  w_hour_nxt = w_inc ? bcd2_inc(r_hour, 8'h00, 8'h23) : bcd2_dec(r_hour, 8'h00, 8'h23);
        S_MIN:   w_min_nxt  = w_inc ? bcd2_inc(r_min, 8'h00, 8'h59)  : bcd2_dec(r_min, 8'h00, 8'h59);
        S_SEC:   w_sec_nxt  = w_inc ? bcd2_inc(r_sec, 8'h00, 8'h59)  : bcd2_dec(r_sec, 8'h00, 8'h59);
        S_DAY:   w_day_nxt  = w_inc ? bcd2_inc(r_day, 8'h01, w_mlen) : bcd2_dec(r_day, 8'h01, w_mlen);
        S_MONTH: w_mon_nxt  = w_inc ? bcd2_inc(r_mon, 8'h01, 8'h12)  : bcd2_dec(r_mon, 8'h01, 8'h12);
        S_YEAR:  w_year_nxt = w_inc ? bcd4_inc(r_year) : bcd4_dec(r_year);
        default: ;
      endcase
    end

    // Keep the day legal for whatever month/year is about to be stored
    w_mlen_nxt = month_len(w_mon_nxt, is_leap(w_year_nxt));
    if (w_day_nxt > w_mlen_nxt) w_day_nxt = w_mlen_nxt;
  end

  // State and counting registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_hour  <= 8'h00;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
      r_day   <= 8'h01;
      r_mon   <= 8'h01;
      r_year  <= RESET_YEAR;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= (w_presc_nxt == PMAX);
      r_hour  <= w_hour_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
      r_day   <= w_day_nxt;
      r_mon   <= w_mon_nxt;
      r_year  <= w_year_nxt;
    end
  end

  assign time_bcd   = {r_hour, r_min, r_sec};
  assign date_bcd   = {r_day, r_mon, r_year};
  assign edit_field = r_state;
  assign tick_1s    = r_tick;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Bench for rtc_calendar_core: cycle-level calendar model in plain integer
// arithmetic, directed calendar cases plus random button traffic.
`timescale 1ns/1ps
module tb_rtc_calendar_core;

  localparam int TD = 4;
  localparam int DB = 8;
`ifdef RTC_DEBOUNCE_EN
  localparam int LAT = DB + 2;
  localparam int LO  = DB + 2;
`else
  localparam int LAT = 2;
  localparam int LO  = 2;
`endif
  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] DEC = 3'b010;
  localparam logic [2:0] CHG = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  raw = 3'b000;
  logic [23:0] time_bcd;
  logic [31:0] date_bcd;
  logic [2:0]  edit_field;
  logic        tick_1s;

  rtc_calendar_core #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .RESET_YEAR(16'h2024)) dut (
    .clk(clk), .rst_n(rst_n),
    .butt_increase(raw[0]), .butt_decrease(raw[1]), .butt_change(raw[2]),
    .time_bcd(time_bcd), .date_bcd(date_bcd), .edit_field(edit_field), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int m_h, m_m, m_s, m_d, m_mo, m_y, m_f, m_presc;
  int edge_cnt = 0;
  int pend_edge = -1;
  logic [2:0] pend_mask = 3'b000;

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      if (n_fail >= 40) begin
        summary();
        $finish;
      end
    end
  endtask

  function automatic bit leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int mlen(input int mo, input int y);
    case (mo)
      2:           return leap(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic logic [7:0] b2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] b4(input int y);
    return {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_d = 1; m_mo = 1; m_y = 2024; m_f = 0; m_presc = 0;
    pend_edge = -1;
  endtask

  task automatic model_tick();
    m_s++;
    if (m_s == 60) begin
      m_s = 0; m_m++;
      if (m_m == 60) begin
        m_m = 0; m_h++;
        if (m_h == 24) begin
          m_h = 0;
          if (m_d == mlen(m_mo, m_y)) begin
            m_d = 1; m_mo++;
            if (m_mo == 13) begin m_mo = 1; m_y = (m_y + 1) % 10000; end
          end else m_d++;
        end
      end
    end
  endtask

  task automatic model_adjust(input bit up);
    int ml;
    ml = mlen(m_mo, m_y);
    case (m_f)
      1: m_h  = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
      2: m_m  = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
      3: m_s  = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
      4: m_d  = up ? (m_d % ml) + 1 : ((m_d == 1) ? ml : m_d - 1);
      5: m_mo = up ? (m_mo % 12) + 1 : ((m_mo == 1) ? 12 : m_mo - 1);
      6: m_y  = up ? (m_y + 1) % 10000 : (m_y + 9999) % 10000;
      default: ;
    endcase
    if (m_d > mlen(m_mo, m_y)) m_d = mlen(m_mo, m_y);
  endtask

  task automatic model_edge();
    edge_cnt++;
    if (m_f == 0) begin
      if (m_presc == TD - 1) begin model_tick(); m_presc = 0; end
      else m_presc++;
    end
    if (edge_cnt == pend_edge) begin
      pend_edge = -1;
      if (pend_mask[2]) begin
        m_f = (m_f + 1) % 7;
        m_presc = 0;
      end else if (m_f != 0 && (pend_mask[0] ^ pend_mask[1])) begin
        model_adjust(pend_mask[0]);
      end
    end
  endtask

  task automatic compare_all();
    check("time", 64'(time_bcd), 64'({b2(m_h), b2(m_m), b2(m_s)}));
    check("date", 64'(date_bcd), 64'({b2(m_d), b2(m_mo), b4(m_y)}));
    check("field", 64'(edit_field), 64'(m_f));
    check("tick", 64'(tick_1s), 64'(m_f == 0 && m_presc == TD - 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Re-arm low phase, then press and return right after the edge where it takes effect
  task automatic press(input logic [2:0] mask, input int extra);
    raw = 3'b000;
    repeat (LO) step();
    raw = mask;
    pend_mask = mask;
    pend_edge = edge_cnt + 1 + LAT;
    repeat (LAT + 1) step();
    repeat (extra) step();
  endtask

  task automatic goto_field(input int f);
    while (m_f != f) press(CHG, 0);
  endtask

  task automatic adjust(input int tgt);
    int lo, span, cur, up;
    case (m_f)
      1: begin lo = 0; span = 24; cur = m_h; end
      2: begin lo = 0; span = 60; cur = m_m; end
      3: begin lo = 0; span = 60; cur = m_s; end
      4: begin lo = 1; span = mlen(m_mo, m_y); cur = m_d; if (tgt > span) tgt = span; end
      5: begin lo = 1; span = 12; cur = m_mo; end
      default: begin lo = 0; span = 10000; cur = m_y; end
    endcase
    up = ((tgt - lo) - (cur - lo) + span) % span;
    if (up <= span - up) repeat (up) press(INC, 0);
    else repeat (span - up) press(DEC, 0);
  endtask

  task automatic set_all(input int h, input int mi, input int s, input int d, input int mo,
                         input int y);
    for (int pass = 0; pass < 3; pass++) begin
      goto_field(1); adjust(h);
      goto_field(2); adjust(mi);
      goto_field(3); adjust(s);
      goto_field(4); adjust(d);
      goto_field(5); adjust(mo);
      goto_field(6); adjust(y);
      goto_field(0);
      if (m_h == h && m_m == mi && m_s == s && m_d == d && m_mo == mo && m_y == y) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    raw = 3'b000;
    #1;
    model_reset();
    compare_all();
    check("rst_time", 64'(time_bcd), 64'(24'h000000));
    check("rst_date", 64'(date_bcd), 64'(32'h01012024));
    check("rst_field", 64'(edit_field), 64'(0));
    check("rst_tick", 64'(tick_1s), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic leap_case(input int y, input logic [31:0] exp_date);
    set_all(23, 59, 59, 28, 2, y);
    repeat (TD) step();
    check("leap_time", 64'(time_bcd), 64'(24'h000000));
    check("leap_date", 64'(date_bcd), 64'(exp_date));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, d0, s0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Calendar rollovers on a tick
    leap_case(2023, 32'h01032023);

    // Month edit clamps the day; leap year keeps day 28
    set_all(12, 0, 0, 31, 1, 2023);
    goto_field(5);
    press(INC, 0);
    check("mon_clamp", 64'(date_bcd), 64'(32'h28022023));
    goto_field(6);
    press(INC, 0);
    check("year_keep", 64'(date_bcd), 64'(32'h28022024));
    press(INC | DEC, 0);
    check("inc_dec", 64'(date_bcd), 64'(32'h28022024));
    press(CHG | INC, 0);
    check("chg_inc_f", 64'(edit_field), 64'(0));
    check("chg_inc_v", 64'(date_bcd), 64'(32'h28022024));

    leap_case(2024, 32'h29022024);
    leap_case(2100, 32'h01032100);
    leap_case(2000, 32'h29022000);

    set_all(23, 59, 59, 31, 12, 9999);
    repeat (TD) step();
    check("y9999_time", 64'(time_bcd), 64'(24'h000000));
    check("y9999_date", 64'(date_bcd), 64'(32'h01010000));

    // Field wraps without carry
    goto_field(2); adjust(0);
    h0 = m_h;
    press(DEC, 0);
    check("min_wrap", 64'(time_bcd[15:8]), 64'(8'h59));
    check("min_hour", 64'(time_bcd[23:16]), 64'(b2(h0)));
    goto_field(1); adjust(23);
    d0 = m_d;
    press(INC, 0);
    check("hour_wrap", 64'(time_bcd[23:16]), 64'(8'h00));
    check("hour_day", 64'(date_bcd[31:24]), 64'(b2(d0)));

    // Held button gives one step
    goto_field(3);
    s0 = m_s;
    press(INC, 100);
    check("held", 64'(time_bcd[7:0]), 64'(b2((s0 + 1) % 60)));

`ifdef RTC_DEBOUNCE_EN
    goto_field(1);
    h0 = m_h;
    raw = 3'b000; repeat (LO) step();
    raw = INC; repeat (5) step();
    raw = 3'b000; repeat (LO) step();
    check("glitch", 64'(time_bcd[23:16]), 64'(b2(h0)));
`endif

    // Random button traffic against the model
    repeat (120) press(3'($urandom_range(0, 7)), $urandom_range(0, 3));
    repeat (2) begin
      set_all($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
              $urandom_range(1, 31), $urandom_range(1, 12),
              (m_y + 10000 + $urandom_range(0, 40) - 20) % 10000);
      repeat (3 * TD) step();
    end

    // Asynchronous reset while editing
    goto_field(5);
    @(negedge clk);
    do_reset();
    repeat (2 * TD) step();

    summary();
    $finish;
  end

endmodule
